// File: rtl/sh7604_dbus_ram_pkg.sv
// Shared types and helpers for the SH7604 DBUS work-RAM responder.
package sh7604_dbus_ram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dbram_state_t;

  // Big-endian lanes: ba[3] covers bits 31:24, i.e. byte offset 0.
  function automatic logic [31:0] ba_lane_mask(input logic [3:0] ba);
    return {{8{ba[3]}}, {8{ba[2]}}, {8{ba[1]}}, {8{ba[0]}}};
  endfunction

endpackage

// File: rtl/sh7604_dbus_ram_mem.sv
// Single-port 2^ADDR_W x 32 RAM with per-lane write enables and a registered
// read port (read-first); no reset so it maps onto block RAM.
module sh7604_dbus_ram_mem
  import sh7604_dbus_ram_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              CLK,
  input  logic [3:0]        WE,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [31:0]       WDATA,
  output logic [31:0]       RDATA
);

  logic [31:0] mem_r [2**ADDR_W];
  logic [31:0] mask_s;

  assign mask_s = ba_lane_mask(WE);

  // Lane-masked write and registered read of the addressed word
  always_ff @(posedge CLK) begin
    if (|WE) begin
      mem_r[ADDR] <= (mem_r[ADDR] & ~mask_s) | (WDATA & mask_s);
    end
    RDATA <= mem_r[ADDR];
  end

endmodule

// File: rtl/sh7604_dbus_ram.sv
// Wait-state-programmable 32-bit RAM responder on the SH7604 data bus.
// Define SH7604_DBUS_RAM_PAGE_EN to enable zero-wait sequential locked bursts.
module sh7604_dbus_ram
  import sh7604_dbus_ram_pkg::*;
#(
  parameter int          ADDR_W      = 10,
  parameter logic [31:0] BASE        = 32'h0600_0000,
  parameter int          WAIT_STATES = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE_R,
  input  logic        CE_F,
  input  logic [31:0] BUS_A,
  input  logic [31:0] BUS_DI,
  output logic [31:0] BUS_DO,
  input  logic [3:0]  BUS_BA,
  input  logic        BUS_WE,
  input  logic        BUS_REQ,
  input  logic        BUS_LOCK,
  output logic        BUS_WAIT,
  output logic        BUS_ACK
);

  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

  dbram_state_t      state_r, state_s;
  logic              sel_s;
  logic [ADDR_W-1:0] bus_idx_s;
  logic [ADDR_W-1:0] idx_r;
  logic [3:0]        ba_r;
  logic              we_r;
  logic [31:0]       di_r;
  logic [3:0]        cnt_r;
  logic [3:0]        cnt_init_s;
  logic [31:0]       do_r;
  logic              accept_s, access_s, abort_s, dec_s;
  logic [ADDR_W-1:0] ram_addr_s;
  logic [3:0]        ram_we_s;
  logic [31:0]       ram_q_s;
  logic              unused_s;

  assign sel_s     = BUS_REQ & (BUS_A[31:ADDR_W+2] == BASE[31:ADDR_W+2]);
  assign bus_idx_s = BUS_A[ADDR_W+1:2];
  assign unused_s  = ^{BUS_A[1:0], BUS_LOCK};

  // Next-state and access strobes; transitions only on the phase enables
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    access_s = 1'b0;
    abort_s  = 1'b0;
    dec_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (CE_R && sel_s) begin
          accept_s = 1'b1;
          state_s  = BUSY;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (!CE_R) begin
          state_s = BUSY;
        end else if (!BUS_REQ) begin
          abort_s = 1'b1;
          state_s = IDLE;
        end else if (cnt_r == 4'd0) begin
          access_s = 1'b1;
          state_s  = DONE;
        end else begin
          dec_s = 1'b1;
        end
      end
      DONE: begin
        if (CE_F) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Request capture, wait-state counter and read-data holding register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      idx_r <= '0;
      ba_r  <= 4'b0000;
      we_r  <= 1'b0;
      di_r  <= 32'd0;
      cnt_r <= 4'd0;
      do_r  <= 32'd0;
    end else begin
      if (accept_s) begin
        idx_r <= bus_idx_s;
        ba_r  <= BUS_BA;
        we_r  <= BUS_WE;
        di_r  <= BUS_DI;
        cnt_r <= cnt_init_s;
      end else if (dec_s) begin
        cnt_r <= cnt_r - 4'd1;
      end
      if (access_s && !we_r) begin
        do_r <= ram_q_s;
      end
    end
  end

`ifdef SH7604_DBUS_RAM_PAGE_EN
  logic              pg_r;
  logic [ADDR_W-1:0] idx_nxt_s;

  assign idx_nxt_s = idx_r + {{(ADDR_W-1){1'b0}}, 1'b1};

  // A sequential access right after a locked one skips the wait states
  always_comb begin
    if (pg_r && (bus_idx_s == idx_nxt_s)) begin
      cnt_init_s = 4'd0;
    end else begin
      cnt_init_s = WS_LOAD;
    end
  end

  // Page flag follows BUS_LOCK at completion; an abort breaks the sequence
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pg_r <= 1'b0;
    end else if (access_s) begin
      pg_r <= BUS_LOCK;
    end else if (abort_s) begin
      pg_r <= 1'b0;
    end
  end
`else
  assign cnt_init_s = WS_LOAD;
`endif

  // In IDLE the RAM is addressed from the bus so its output is valid
  // from the accepting edge onward, even with zero wait states.
  always_comb begin
    if (state_r == IDLE) begin
      ram_addr_s = bus_idx_s;
    end else begin
      ram_addr_s = idx_r;
    end
    if (access_s && we_r) begin
      ram_we_s = ba_r;
    end else begin
      ram_we_s = 4'b0000;
    end
  end

  sh7604_dbus_ram_mem #(
    .ADDR_W (ADDR_W)
  ) u_mem (
    .CLK   (CLK),
    .WE    (ram_we_s),
    .ADDR  (ram_addr_s),
    .WDATA (di_r),
    .RDATA (ram_q_s)
  );

  assign BUS_DO   = do_r;
  assign BUS_ACK  = (state_r == DONE);
  assign BUS_WAIT = sel_s & (state_r != DONE);

endmodule

// File: tb/tb_sh7604_dbus_ram.sv
// Directed self-checking bench for sh7604_dbus_ram: unit 0 uses 2 wait states,
// unit 1 uses 3 wait states for the sequential/page-mode sequence.
module tb_sh7604_dbus_ram;

  localparam logic [31:0] BASE = 32'h0600_0000;
`ifdef SH7604_DBUS_RAM_PAGE_EN
  localparam int HIT_SLOTS = 1;
`else
  localparam int HIT_SLOTS = 4;
`endif

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        CE_R = 1'b0;
  logic        CE_F = 1'b0;
  logic [31:0] BUS_A = 32'd0;
  logic [31:0] BUS_DI = 32'd0;
  logic [3:0]  BUS_BA = 4'b0000;
  logic        BUS_WE = 1'b0;
  logic        BUS_LOCK = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [31:0] do0, do1;
  logic        wait0, wait1, ack0, ack1;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  sh7604_dbus_ram #(.ADDR_W(10), .BASE(BASE), .WAIT_STATES(2)) u_dut0 (
    .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .CE_F(CE_F),
    .BUS_A(BUS_A), .BUS_DI(BUS_DI), .BUS_DO(do0), .BUS_BA(BUS_BA),
    .BUS_WE(BUS_WE), .BUS_REQ(req[0]), .BUS_LOCK(BUS_LOCK),
    .BUS_WAIT(wait0), .BUS_ACK(ack0)
  );

  sh7604_dbus_ram #(.ADDR_W(10), .BASE(BASE), .WAIT_STATES(3)) u_dut1 (
    .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .CE_F(CE_F),
    .BUS_A(BUS_A), .BUS_DI(BUS_DI), .BUS_DO(do1), .BUS_BA(BUS_BA),
    .BUS_WE(BUS_WE), .BUS_REQ(req[1]), .BUS_LOCK(BUS_LOCK),
    .BUS_WAIT(wait1), .BUS_ACK(ack1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic cur_wait(input int u);
    return (u == 0) ? wait0 : wait1;
  endfunction

  function automatic logic cur_ack(input int u);
    return (u == 0) ? ack0 : ack1;
  endfunction

  function automatic logic [31:0] cur_do(input int u);
    return (u == 0) ? do0 : do1;
  endfunction

  // One CLK cycle with the given enables; outputs are sampled 1ns after the edge
  task automatic tick(input logic r, input logic f);
    CE_R = r;
    CE_F = f;
    @(posedge CLK);
    #1;
    CE_R = 1'b0;
    CE_F = 1'b0;
  endtask

  // Full handshake with alternating CE_R/CE_F; slots = CE_R slots after accept up to DONE
  task automatic bus_access(input int u, input logic we, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] ba, input logic lock,
                            output int slots, output int waits, output int acks);
    bit done;
    int r_ticks;
    done = 1'b0;
    r_ticks = 0;
    waits = 0;
    acks = 0;
    BUS_A = a; BUS_DI = d; BUS_BA = ba; BUS_WE = we; BUS_LOCK = lock;
    req[u] = 1'b1;
    for (int n = 0; n < 40 && !done; n++) begin
      tick(1'b1, 1'b0);
      r_ticks++;
      if (cur_wait(u)) waits++;
      if (cur_ack(u)) begin
        acks++;
        done = 1'b1;
      end
      tick(1'b0, 1'b1);
      if (cur_ack(u)) acks++;
    end
    req[u] = 1'b0;
    slots = r_ticks - 1;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout: no ACK at addr %h after 40 CE_R slots", a);
    end
  endtask

  task automatic outside(input logic [31:0] a);
    int w, k;
    w = 0;
    k = 0;
    BUS_A = a; BUS_WE = 1'b1; BUS_BA = 4'b1111; BUS_DI = 32'h0BAD_0BAD;
    req[0] = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick(1'b1, 1'b0);
      if (wait0) w++;
      if (ack0) k++;
      tick(1'b0, 1'b1);
      if (wait0) w++;
      if (ack0) k++;
    end
    req[0] = 1'b0;
    check_eq("oow_wait", 32'(w), 32'd0);
    check_eq("oow_ack", 32'(k), 32'd0);
  endtask

  initial begin
    int s, w, k;

    tick(1'b0, 1'b0);
    tick(1'b1, 1'b1);
    check_eq("rst_do0", do0, 32'd0);
    check_eq("rst_ack0", 32'(ack0), 32'd0);
    check_eq("rst_wait0", 32'(wait0), 32'd0);
    check_eq("rst_do1", do1, 32'd0);
    check_eq("rst_ack1", 32'(ack1), 32'd0);
    RST_N = 1'b1;
    tick(1'b0, 1'b0);

    // Word write then read back
    bus_access(0, 1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 4'b1111, 1'b0, s, w, k);
    check_eq("wr_slots", 32'(s), 32'd3);
    check_eq("wr_waits", 32'(w), 32'd3);
    check_eq("wr_acks", 32'(k), 32'd1);
    bus_access(0, 1'b0, BASE + 32'h10, 32'd0, 4'b0001, 1'b0, s, w, k);
    check_eq("rd_slots", 32'(s), 32'd3);
    check_eq("rd_acks", 32'(k), 32'd1);
    check_eq("rd_word", do0, 32'hDEAD_BEEF);

    // Single byte lane; BUS_A[1:0] is ignored
    bus_access(0, 1'b1, BASE + 32'h11, 32'h1122_3344, 4'b0100, 1'b0, s, w, k);
    bus_access(0, 1'b0, BASE + 32'h10, 32'd0, 4'b1111, 1'b0, s, w, k);
    check_eq("rd_lane", do0, 32'hDE22_BEEF);

    // No lanes enabled still completes
    bus_access(0, 1'b1, BASE + 32'h10, 32'hFFFF_FFFF, 4'b0000, 1'b0, s, w, k);
    check_eq("ba0_slots", 32'(s), 32'd3);
    bus_access(0, 1'b0, BASE + 32'h10, 32'd0, 4'b1111, 1'b0, s, w, k);
    check_eq("ba0_word", do0, 32'hDE22_BEEF);

    // Last word of the window with top lane only
    bus_access(0, 1'b1, BASE + 32'hFFC, 32'hCAFE_F00D, 4'b1111, 1'b0, s, w, k);
    bus_access(0, 1'b1, BASE + 32'hFFF, 32'h5A00_0000, 4'b1000, 1'b0, s, w, k);
    bus_access(0, 1'b0, BASE + 32'hFFC, 32'd0, 4'b0000, 1'b0, s, w, k);
    check_eq("top_word", do0, 32'h5AFE_F00D);

    // Requests outside the window on both sides
    outside(BASE - 32'd4);
    outside(BASE + 32'h1000);
    check_eq("oow_do", do0, 32'h5AFE_F00D);
    bus_access(0, 1'b0, BASE + 32'h10, 32'd0, 4'b1111, 1'b0, s, w, k);
    check_eq("oow_next_slots", 32'(s), 32'd3);
    check_eq("oow_next_word", do0, 32'hDE22_BEEF);

    // Abort with CNT==1
    BUS_A = BASE + 32'h10; BUS_DI = 32'h0000_0000; BUS_BA = 4'b1111; BUS_WE = 1'b1;
    req[0] = 1'b1;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    req[0] = 1'b0;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    check_eq("abort_ack", 32'(ack0), 32'd0);
    bus_access(0, 1'b0, BASE + 32'h10, 32'd0, 4'b1111, 1'b0, s, w, k);
    check_eq("abort_slots", 32'(s), 32'd3);
    check_eq("abort_word", do0, 32'hDE22_BEEF);

    // Coincident CE_R/CE_F: DONE->IDLE only, accept on the following CE_R
    BUS_A = BASE + 32'h10; BUS_WE = 1'b0; BUS_BA = 4'b1111;
    req[0] = 1'b1;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    check_eq("co_done_ack", 32'(ack0), 32'd1);
    tick(1'b1, 1'b1);
    check_eq("co_idle_ack", 32'(ack0), 32'd0);
    check_eq("co_idle_wait", 32'(wait0), 32'd1);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    check_eq("co_not_early", 32'(ack0), 32'd0);
    tick(1'b1, 1'b0);
    check_eq("co_done2_ack", 32'(ack0), 32'd1);
    tick(1'b0, 1'b1);
    req[0] = 1'b0;
    tick(1'b0, 1'b0);

    // Reset in BUSY drops the pending write
    BUS_A = BASE + 32'h10; BUS_DI = 32'h5555_5555; BUS_BA = 4'b1111; BUS_WE = 1'b1;
    req[0] = 1'b1;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b0);
    req[0] = 1'b0;
    RST_N = 1'b0;
    tick(1'b1, 1'b0);
    check_eq("mrst_do", do0, 32'd0);
    check_eq("mrst_ack", 32'(ack0), 32'd0);
    check_eq("mrst_wait", 32'(wait0), 32'd0);
    RST_N = 1'b1;
    tick(1'b0, 1'b0);
    bus_access(0, 1'b0, BASE + 32'h10, 32'd0, 4'b1111, 1'b0, s, w, k);
    check_eq("mrst_word", do0, 32'hDE22_BEEF);

    // Sequential locked reads on the 3-wait-state unit
    for (int i = 0; i < 4; i++) begin
      bus_access(1, 1'b1, BASE + 32'(4 * i), 32'h1000_0000 + 32'(i), 4'b1111, 1'b0, s, w, k);
      check_eq("pg_wr_slots", 32'(s), 32'd4);
    end
    for (int i = 0; i < 4; i++) begin
      bus_access(1, 1'b0, BASE + 32'(4 * i), 32'd0, 4'b1111, 1'b1, s, w, k);
      check_eq("pg_rd_slots", 32'(s), (i == 0) ? 32'd4 : 32'(HIT_SLOTS));
      check_eq("pg_rd_word", do1, 32'h1000_0000 + 32'(i));
    end
    bus_access(1, 1'b0, BASE + 32'h10, 32'd0, 4'b1111, 1'b0, s, w, k);
    check_eq("pg_tail_slots", 32'(s), 32'(HIT_SLOTS));
    bus_access(1, 1'b0, BASE + 32'h14, 32'd0, 4'b1111, 1'b0, s, w, k);
    check_eq("pg_cleared_slots", 32'(s), 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
